// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: fetches 16-bit code words at CS:fetch_offset,
// splits them into bytes and hands them to the decoder in show-ahead order.
module prefetch_unit #(
  parameter int FIFO_DEPTH = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [15:0]                        cs,
  input  logic [15:0]                        new_ip,
  input  logic                               load_new_ip,
  output logic [18:0]                        mem_address,
  output logic                               mem_access,
  input  logic                               mem_ack,
  input  logic [15:0]                        mem_data,
  input  logic                               fifo_rd_en,
  output logic [7:0]                         fifo_rd_data,
  output logic                               fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ABORT} state_t;

  state_t             state;
  logic [15:0]        fetch_offset;
  logic [7:0]         queue [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic [19:0]        phys;
  logic               has_room;
  logic               accept;
  logic               push_two;
  logic               push_one;
  logic               pop;
  logic [CNT_W-1:0]   push_n;

  // Queue depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // 8086 addressing: segment*16 + offset, truncated to 20 bits.
  assign phys     = {cs, 4'h0} + {4'h0, fetch_offset};
  assign has_room = (count <= CNT_W'(FIFO_DEPTH - 2));
  assign accept   = (state == REQ) && mem_ack && !load_new_ip;
  assign push_two = accept && !fetch_offset[0];
  assign push_one = accept && fetch_offset[0];
  assign pop      = fifo_rd_en && (count != '0) && !load_new_ip;
  assign push_n   = push_two ? CNT_W'(2) : (push_one ? CNT_W'(1) : '0);

  assign fifo_count   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_rd_data = fifo_empty ? 8'h00 : queue[rd_ptr];

  // Byte storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_two) begin
      queue[wr_ptr]          <= mem_data[7:0];
      queue[ptr_inc(wr_ptr)] <= mem_data[15:8];
    end else if (push_one) begin
      queue[wr_ptr]          <= mem_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_access   <= 1'b0;
      fetch_offset <= 16'h0000;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      if (load_new_ip) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        fetch_offset <= new_ip;
      end else begin
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push_two) begin
          wr_ptr       <= ptr_inc(ptr_inc(wr_ptr));
          fetch_offset <= fetch_offset + 16'd2;
        end else if (push_one) begin
          wr_ptr       <= ptr_inc(wr_ptr);
          fetch_offset <= fetch_offset + 16'd1;
        end
        count <= count + push_n - CNT_W'(pop);
      end

      case (state)
        IDLE: begin
          if (has_room && !load_new_ip) begin
            state       <= REQ;
            mem_access  <= 1'b1;
            mem_address <= phys[19:1];
          end
        end
        REQ: begin
          // An ack always ends the transaction, even when a flush discards it.
          if (mem_ack) begin
            state      <= IDLE;
            mem_access <= 1'b0;
          end else if (load_new_ip) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_access <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mem_access <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios plus a randomized run against a
// byte-queue reference model.
module tb_prefetch_unit;

  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cs;
  logic [15:0] new_ip;
  logic        load_new_ip;
  logic [18:0] mem_address;
  logic        mem_access;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  // memory responder controls
  bit          mem_auto = 1'b1;
  bit          rand_lat = 1'b0;
  int          mem_lat  = 1;
  int          wcnt     = 0;
  logic [18:0] req_log[$];

  // reference model
  logic [7:0]  mq[$];
  logic [15:0] m_off   = 16'h0000;
  bit          m_pend  = 1'b0;
  bit          m_stale = 1'b0;
  logic [18:0] m_addr  = '0;

  always #5 clk = ~clk;

  prefetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .new_ip       (new_ip),
    .load_new_ip  (load_new_ip),
    .mem_address  (mem_address),
    .mem_access   (mem_access),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count)
  );

  function automatic logic [7:0] byte_val(input logic [19:0] p);
    return p[7:0] ^ p[15:8] ^ {4'h0, p[19:16]};
  endfunction

  function automatic logic [15:0] word_at(input logic [18:0] a);
    return {byte_val({a, 1'b1}), byte_val({a, 1'b0})};
  endfunction

  task automatic model_update();
    int          sz;
    logic [19:0] p;
    sz = mq.size();
    if (reset) begin
      mq.delete(); m_off = 16'h0000; m_pend = 1'b0; m_stale = 1'b0;
    end else if (load_new_ip) begin
      mq.delete();
      m_off = new_ip;
      if (m_pend) begin
        if (mem_ack) begin m_pend = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else begin
      if (fifo_rd_en && sz > 0) void'(mq.pop_front());
      if (m_pend) begin
        if (mem_ack) begin
          if (!m_stale) begin
            if (m_off[0]) begin
              mq.push_back(mem_data[15:8]); m_off = m_off + 16'd1;
            end else begin
              mq.push_back(mem_data[7:0]); mq.push_back(mem_data[15:8]);
              m_off = m_off + 16'd2;
            end
          end
          m_pend = 1'b0; m_stale = 1'b0;
        end
      end else if (DEPTH - sz >= 2) begin
        p = {cs, 4'h0} + {4'h0, m_off};
        m_pend = 1'b1;
        m_addr = p[19:1];
      end
    end
  endtask

  // One clock: memory responds, model advances, then sample 1 time unit after the edge.
  task automatic step();
    if (mem_auto) begin
      mem_ack = 1'b0;
      if (mem_access) begin
        if (wcnt == 0) req_log.push_back(mem_address);
        wcnt++;
        if (wcnt >= mem_lat) begin
          mem_ack  = 1'b1;
          mem_data = word_at(mem_address);
          wcnt     = 0;
          if (rand_lat) mem_lat = $urandom_range(1, 4);
        end
      end else begin
        wcnt = 0;
      end
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_new_ip = 1'b0; fifo_rd_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty); else n_pass++;
    n_checks++; if (mem_access !== 1'b0) $display("FAIL reset_access: got %b want 0", mem_access); else n_pass++;
    n_checks++; if (fifo_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", fifo_rd_data); else n_pass++;
  endtask

  task automatic test_fill();
    mem_auto = 1'b1; rand_lat = 1'b0; mem_lat = 1; cs = 16'h0000;
    do_reset();
    req_log.delete();
    for (int i = 0; i < 30 && fifo_count != 3'd6; i++) step();
    step(); step(); step();
    n_checks++; if (req_log.size() != 3) $display("FAIL fill_nreq: got %0d want 3", req_log.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (req_log.size() <= k || req_log[k] !== 19'(k)) $display("FAIL fill_addr%0d: got %h want %h", k, (req_log.size() > k) ? req_log[k] : 19'h7ffff, 19'(k));
      else n_pass++;
    end
    n_checks++; if (fifo_count !== 3'd6) $display("FAIL fill_count: got %0d want 6", fifo_count); else n_pass++;
    n_checks++; if (mem_access !== 1'b0) $display("FAIL fill_access_full: got %b want 0", mem_access); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (fifo_rd_data !== 8'(i)) $display("FAIL fill_pop%0d: got %h want %h", i, fifo_rd_data, 8'(i)); else n_pass++;
      fifo_rd_en = 1'b1;
      step();
    end
    fifo_rd_en = 1'b0;
  endtask

  task automatic test_odd_restart();
    mem_auto = 1'b1; mem_lat = 1;
    do_reset();
    load_new_ip = 1'b1; cs = 16'h1000; new_ip = 16'h0101;
    step();
    load_new_ip = 1'b0;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h08080) $display("FAIL odd_addr0: got %b/%h want 1/08080", mem_access, mem_address); else n_pass++;
    step();
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL odd_count1: got %0d want 1", fifo_count); else n_pass++;
    n_checks++; if (fifo_rd_data !== 8'h01) $display("FAIL odd_byte: got %h want 01", fifo_rd_data); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h08081) $display("FAIL odd_addr1: got %b/%h want 1/08081", mem_access, mem_address); else n_pass++;
    step();
    n_checks++; if (fifo_count !== 3'd3) $display("FAIL odd_count3: got %0d want 3", fifo_count); else n_pass++;
  endtask

  task automatic test_flush_pending();
    mem_auto = 1'b1; mem_lat = 3; cs = 16'h0000;
    do_reset();
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) $display("FAIL flush_req: got %b/%h want 1/00000", mem_access, mem_address); else n_pass++;
    load_new_ip = 1'b1; new_ip = 16'h0200;
    step();
    load_new_ip = 1'b0;
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) $display("FAIL flush_hold1: got %b/%h want 1/00000", mem_access, mem_address); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL flush_count1: got %0d want 0", fifo_count); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) $display("FAIL flush_hold2: got %b/%h want 1/00000", mem_access, mem_address); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b0 || fifo_count !== 3'd0) $display("FAIL flush_discard: got %b/%0d want 0/0", mem_access, fifo_count); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00100) $display("FAIL flush_newreq: got %b/%h want 1/00100", mem_access, mem_address); else n_pass++;
    step(); step(); step();
    n_checks++; if (fifo_count !== 3'd2 || fifo_rd_data !== 8'h02) $display("FAIL flush_data: got %0d/%h want 2/02", fifo_count, fifo_rd_data); else n_pass++;
    mem_lat = 1;
  endtask

  task automatic test_free_space();
    mem_auto = 1'b1; mem_lat = 1; cs = 16'h0000;
    do_reset();
    for (int i = 0; i < 30 && fifo_count != 3'd6; i++) step();
    step(); step();
    n_checks++; if (fifo_count !== 3'd6 || mem_access !== 1'b0) $display("FAIL gate_full: got %0d/%b want 6/0", fifo_count, mem_access); else n_pass++;
    fifo_rd_en = 1'b1; step(); fifo_rd_en = 1'b0;
    n_checks++; if (fifo_count !== 3'd5) $display("FAIL gate_count5: got %0d want 5", fifo_count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (mem_access !== 1'b0) $display("FAIL gate_noreq%0d: got %b want 0", i, mem_access); else n_pass++;
    end
    fifo_rd_en = 1'b1; step(); fifo_rd_en = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) $display("FAIL gate_count4: got %0d want 4", fifo_count); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00003) $display("FAIL gate_req: got %b/%h want 1/00003", mem_access, mem_address); else n_pass++;
    fifo_rd_en = 1'b1; step(); fifo_rd_en = 1'b0;
    n_checks++; if (fifo_count !== 3'd5) $display("FAIL gate_pop_push: got %0d want 5", fifo_count); else n_pass++;
    n_checks++; if (fifo_rd_data !== 8'h03) $display("FAIL gate_head: got %h want 03", fifo_rd_data); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b0) $display("FAIL gate_idle5: got %b want 0", mem_access); else n_pass++;
  endtask

  task automatic test_wrap();
    mem_auto = 1'b1; mem_lat = 1;
    do_reset();
    load_new_ip = 1'b1; cs = 16'hF000; new_ip = 16'hFFFF;
    step();
    load_new_ip = 1'b0; fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h7FFFF) $display("FAIL wrap_addr0: got %b/%h want 1/7ffff", mem_access, mem_address); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0 || fifo_empty !== 1'b1) $display("FAIL wrap_empty_pop: got %0d/%b want 0/1", fifo_count, fifo_empty); else n_pass++;
    step();
    n_checks++; if (fifo_count !== 3'd1 || fifo_rd_data !== 8'h0F) $display("FAIL wrap_byte: got %0d/%h want 1/0f", fifo_count, fifo_rd_data); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h78000) $display("FAIL wrap_addr1: got %b/%h want 1/78000", mem_access, mem_address); else n_pass++;
  endtask

  task automatic test_coincident();
    mem_auto = 1'b0; mem_ack = 1'b0; cs = 16'h0000;
    do_reset();
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00000) $display("FAIL coin_req: got %b/%h want 1/00000", mem_access, mem_address); else n_pass++;
    mem_ack = 1'b1; mem_data = word_at(19'h00000); load_new_ip = 1'b1; new_ip = 16'h0040;
    step();
    mem_ack = 1'b0; load_new_ip = 1'b0;
    n_checks++; if (fifo_count !== 3'd0 || mem_access !== 1'b0) $display("FAIL coin_discard: got %0d/%b want 0/0", fifo_count, mem_access); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00020) $display("FAIL coin_newreq: got %b/%h want 1/00020", mem_access, mem_address); else n_pass++;
    mem_ack = 1'b1; mem_data = word_at(19'h00020);
    step();
    mem_ack = 1'b0;
    n_checks++; if (fifo_count !== 3'd2) $display("FAIL coin_push: got %0d want 2", fifo_count); else n_pass++;
    step();
    n_checks++; if (mem_access !== 1'b1 || mem_address !== 19'h00021) $display("FAIL coin_req2: got %b/%h want 1/00021", mem_access, mem_address); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (mem_access !== 1'b0 || fifo_empty !== 1'b1 || fifo_count !== 3'd0) $display("FAIL coin_reset: got %b/%b/%0d want 0/1/0", mem_access, fifo_empty, fifo_count); else n_pass++;
    mem_auto = 1'b1; wcnt = 0;
  endtask

  task automatic test_random();
    int r;
    mem_auto = 1'b1; rand_lat = 1'b1; mem_lat = 2;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fifo_rd_en  = ($urandom_range(0, 99) < 55);
      r           = $urandom_range(0, 99);
      load_new_ip = (r < 4);
      if (load_new_ip) begin
        new_ip = 16'($urandom);
        if (r < 2) cs = 16'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
      n_checks++; if (mem_access !== m_pend) $display("FAIL rnd_access c%0d: got %b want %b", c, mem_access, m_pend); else n_pass++;
      if (m_pend) begin
        n_checks++; if (mem_address !== m_addr) $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_address, m_addr); else n_pass++;
      end
      n_checks++; if (fifo_count !== 3'(mq.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, mq.size()); else n_pass++;
      n_checks++; if (fifo_empty !== (mq.size() == 0)) $display("FAIL rnd_empty c%0d: got %b want %b", c, fifo_empty, (mq.size() == 0)); else n_pass++;
      if (mq.size() > 0) begin
        n_checks++; if (fifo_rd_data !== mq[0]) $display("FAIL rnd_head c%0d: got %h want %h", c, fifo_rd_data, mq[0]); else n_pass++;
      end
    end
    reset = 1'b0; load_new_ip = 1'b0; fifo_rd_en = 1'b0; rand_lat = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cs = 16'h0000; new_ip = 16'h0000; load_new_ip = 1'b0;
    mem_ack = 1'b0; mem_data = 16'h0000; fifo_rd_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_odd_restart();
    test_flush_pending();
    test_free_space();
    test_wrap();
    test_coincident();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Instruction-byte producer that runs ahead of the IP register.
- Fetches 16-bit words from code memory at CS:fetch_offset and splits them into bytes in a small FIFO for the decoder.
- Restarts from a new offset whenever IP is overwritten (jump, call, interrupt).
- The decoder pops bytes; the IP register advances by the consumed count.

Parameters:
FIFO_DEPTH, 6, byte capacity of the prefetch queue; must be even and at least 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; the only clock is clk
cs  in  16  code segment; changes only in a cycle where load_new_ip=1
new_ip  in  16  restart offset, same value written to IP
load_new_ip  in  1  flush the queue and restart fetching at new_ip
mem_address  out  19  word address, physical[19:1]
mem_access  out  1  bus request; held until mem_ack
mem_ack  in  1  one-cycle completion strobe; mem_data valid in the same cycle
mem_data  in  16  fetched word; low byte is the even address
fifo_rd_en  in  1  pop one byte
fifo_rd_data  out  8  head byte, show-ahead (valid whenever fifo_empty=0)
fifo_empty  out  1  queue empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes held

Behaviour:
- Reset values: fetch_offset=0, queue empty, fifo_count=0, fifo_empty=1, mem_access=0, state IDLE, fifo_rd_data=0.
- Reset mid-transaction: mem_access drops the same edge. The bus is reset with the CPU, so no abort handshake is needed.
- Physical address = (cs<<4) + fetch_offset, 20-bit sum truncated mod 2^20. mem_address = phys[19:1].
- States:
  - IDLE: go to REQ when (FIFO_DEPTH - fifo_count) >= 2 and load_new_ip=0. mem_access=1 from the next cycle.
  - REQ: mem_access=1 with a stable mem_address.
    - On mem_ack with no flush, push data:
      - even fetch_offset: push mem_data[7:0], then mem_data[15:8]; offset += 2.
      - odd fetch_offset: push mem_data[15:8] only; offset += 1.
    - After the push, return to IDLE.
  - ABORT: entered from REQ when load_new_ip=1 without mem_ack that cycle.
    - mem_access and mem_address are held unchanged until mem_ack.
    - Acked data is discarded, then go to IDLE.
    - A further load_new_ip while in ABORT updates fetch_offset only.
- fetch_offset is 16 bits and wraps 0xFFFF -> 0x0000. No segment carry into cs (8086 semantics).
- load_new_ip:
  - Same edge: queue cleared (count 0), fetch_offset <= new_ip.
  - Priority over push and pop in that cycle.
  - Coincident with mem_ack: data discarded and the transaction counts as finished, so next state is IDLE.
- Pop:
  - fifo_rd_en with fifo_empty=0 removes the head at the edge.
  - fifo_rd_en while empty is ignored.
  - Pop and push in the same cycle: count += pushed - 1. No overflow is possible because of the >=2 free-space rule.
- Latency:
  - Byte acked at edge N is visible on fifo_rd_data at N+1.
  - After load_new_ip at edge N with an idle bus, mem_access=1 from N+1.
- mem_access never deasserts in REQ/ABORT before mem_ack.

Test Plan:
1. Fill to capacity: reset, cs=0; memory acks 1 cycle after request with data={addr+1,addr} -> requests at mem_address 0x00000, 0x00001, 0x00002; fifo_count reaches 6; bytes pop as 0x00,0x01,...,0x05; mem_access=0 when full.
2. Odd restart: cs=0x1000, load_new_ip new_ip=0x0101 -> first mem_address=0x08080, single byte mem_data[15:8] pushed, next mem_address=0x08081, fifo_count=1 then 3.
3. Flush during pending request: cs=0, mem_ack delayed 3 cycles, load_new_ip=1 with new_ip=0x0200 one cycle after request -> old mem_address held until ack, fifo_count stays 0, next request at mem_address 0x00100.
4. Free-space gating: full queue (6), pop 1 -> count 5, no request issued; pop another -> count 4, mem_access=1 next cycle; pop in the ack cycle -> count 5.
5. Wrap-around: cs=0xF000, new_ip=0xFFFF -> mem_address=0x7FFFF, one byte pushed, fetch_offset=0x0000, next mem_address=0x78000.
6. Coincident events: mem_ack in the same cycle as load_new_ip -> fifo_count=0, data discarded, new request issued next cycle at new_ip. Reset asserted while mem_access=1 -> mem_access=0 and fifo_empty=1 after the edge.
